// File: rtl/dds_pkg.sv
// Shared constants, sample type and saturation helper for the DDS channel datapath.
package dds_pkg;

  localparam int unsigned PHASE_W  = 32;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned AMP_W    = 16;
  localparam int unsigned AMP_FRAC = 15;
  localparam int unsigned PROD_W   = DATA_W + AMP_W + 1;
  localparam int unsigned SUM_W    = 19;

  localparam logic [AMP_W-1:0] AMP_UNITY = 16'h8000;

  localparam logic signed [SUM_W-1:0] SAT_MAX = 19'sd32767;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -19'sd32768;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Clamp a 19-bit signed sum into the 16-bit signed sample range.
  function automatic sample_t sat16(input logic signed [SUM_W-1:0] s);
    sample_t r;
    if (s > SAT_MAX) begin
      r = 16'sh7FFF;
    end else if (s < SAT_MIN) begin
      r = 16'sh8000;
    end else begin
      r = s[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dds_sample_scaler.sv
// Amplitude scaling and DC offset with saturation: multiply stage then output stage.
module dds_sample_scaler
  import dds_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] i_ram_q,
  input  logic              i_vc,
  input  logic [AMP_W-1:0]  i_amp,
  input  logic [DATA_W-1:0] i_dc,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_valid
);

  logic signed [PROD_W-1:0] r_prod;
  logic                     r_vm;
  sample_t                  r_sample;
  logic                     r_valid;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [SUM_W-1:0]  w_sum;

  // Signed sample times zero-extended (non-negative) gain, both widened to the product width.
  assign w_prod = $signed({{(PROD_W-DATA_W){i_ram_q[DATA_W-1]}}, i_ram_q})
                * $signed({{(PROD_W-AMP_W){1'b0}}, i_amp});

  // Arithmetic shift floors toward minus infinity; result fits in 18 bits before the DC add.
  assign w_sum = SUM_W'(r_prod >>> AMP_FRAC) + SUM_W'($signed(i_dc));

  // Multiply and output stages; data registers load only with a valid so the output holds between samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prod   <= '0;
      r_vm     <= 1'b0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_vm    <= i_vc;
      r_valid <= r_vm;
      if (i_vc) begin
        r_prod <= w_prod;
      end
      if (r_vm) begin
        r_sample <= sat16(w_sum);
      end
    end
  end

  assign o_sample = r_sample;
  assign o_valid  = r_valid;

endmodule

// File: rtl/dds_phase_sample_engine.sv
// Single DDS channel: phase accumulator, lookup RAM address generation, sample capture and scaling.
module dds_phase_sample_engine
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               phase_reset,
  input  logic               load,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic [PHASE_W-1:0] poff_in,
  input  logic [AMP_W-1:0]   amp_in,
  input  logic [DATA_W-1:0]  dc_in,
  output logic [ADDR_W-1:0]  ram_address,
  output logic               ram_chipselect,
  output logic               ram_write,
  output logic [1:0]         ram_byteenable,
  input  logic [DATA_W-1:0]  ram_readdata,
  output logic [DATA_W-1:0]  sample_out,
  output logic               sample_valid,
  output logic               wrap_pulse,
  output logic               sync_out
);

  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_ftw;
  logic [PHASE_W-1:0] r_poff;
  logic [AMP_W-1:0]   r_amp;
  logic [DATA_W-1:0]  r_dc;
  logic               r_wrap;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_va;
  logic               r_vr;
  logic               r_vc;
  logic [DATA_W-1:0]  r_ram_q;

  logic [PHASE_W:0]   w_acc_sum;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_ftw};

  // Active register set: all four values commit on the same load edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ftw  <= '0;
      r_poff <= '0;
      r_amp  <= AMP_UNITY;
      r_dc   <= '0;
    end else if (load) begin
      r_ftw  <= ftw_in;
      r_poff <= poff_in;
      r_amp  <= amp_in;
      r_dc   <= dc_in;
    end
  end

  // Phase accumulator with carry-out pulse; phase_reset takes priority over enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (phase_reset) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (enable) begin
      {r_wrap, r_acc} <= w_acc_sum;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Address stage: top phase bits of the pre-increment accumulator plus offset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_va   <= 1'b0;
    end else if (phase_reset) begin
      r_addr <= ADDR_W'(r_poff >> (PHASE_W - ADDR_W));
      r_va   <= enable;
    end else if (enable) begin
      r_addr <= ADDR_W'((r_acc + r_poff) >> (PHASE_W - ADDR_W));
      r_va   <= 1'b1;
    end else begin
      r_va   <= 1'b0;
    end
  end

  // RAM latch edge then capture of the unregistered read data one edge later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vr    <= 1'b0;
      r_vc    <= 1'b0;
      r_ram_q <= '0;
    end else begin
      r_vr <= r_va;
      r_vc <= r_vr;
      if (r_vr) begin
        r_ram_q <= ram_readdata;
      end
    end
  end

  dds_sample_scaler u_scaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_ram_q  (r_ram_q),
    .i_vc     (r_vc),
    .i_amp    (r_amp),
    .i_dc     (r_dc),
    .o_sample (sample_out),
    .o_valid  (sample_valid)
  );

  assign ram_address    = r_addr;
  assign ram_chipselect = 1'b1;
  assign ram_write      = 1'b0;
  assign ram_byteenable = 2'b11;
  assign wrap_pulse     = r_wrap;
  assign sync_out       = r_acc[PHASE_W-1];

endmodule

// File: tb/tb_dds_phase_sample_engine.sv
// Self-checking bench for dds_phase_sample_engine against a behavioural phase/sample model.
module tb_dds_phase_sample_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        phase_reset;
  logic        load;
  logic [31:0] ftw_in;
  logic [31:0] poff_in;
  logic [15:0] amp_in;
  logic [15:0] dc_in;
  logic [9:0]  ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [1:0]  ram_byteenable;
  logic [15:0] ram_readdata;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        wrap_pulse;
  logic        sync_out;

  always #5 clk = ~clk;

  dds_phase_sample_engine dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .phase_reset    (phase_reset),
    .load           (load),
    .ftw_in         (ftw_in),
    .poff_in        (poff_in),
    .amp_in         (amp_in),
    .dc_in          (dc_in),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_readdata   (ram_readdata),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .wrap_pulse     (wrap_pulse),
    .sync_out       (sync_out)
  );

  // Lookup RAM second port: address registered at the edge, read data combinational.
  logic [15:0] mem [1024];
  logic [9:0]  ram_a_q = '0;
  always @(posedge clk) ram_a_q <= ram_address;
  assign ram_readdata = mem[ram_a_q];

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input longint expv);
    n_tot++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  // Reference: sample = clamp(floor(ram*amp/32768) + dc)
  function automatic int scale(input int v, input int a, input int d);
    longint p, qq, s;
    p  = longint'(v) * longint'(a);
    qq = p / 32768;
    if (p < 0 && (p % 32768) != 0) qq = qq - 1;
    s = qq + d;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  localparam longint unsigned TWO32 = 64'h1_0000_0000;
  localparam int LAT = 4;

  typedef struct { int due; int addr; } req_t;
  req_t q[$];

  longint unsigned m_acc, m_ftw, m_poff, s_acc;
  int  m_amp, m_dc;
  int  amp_h [8192];
  int  dc_h  [8192];
  int  cyc = 0;
  bit  chk_en = 0;
  int  e_addr, e_sample;
  bit  e_valid, e_wrap;

  // Model advances once per rising edge, seeing the same inputs the DUT samples.
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_acc = 0; m_ftw = 0; m_poff = 0; m_amp = 32768; m_dc = 0;
      q.delete();
      e_addr = 0; e_sample = 0; e_valid = 0; e_wrap = 0;
      amp_h[cyc] = 32768; dc_h[cyc] = 0;
      chk_en = 1;
    end else begin
      amp_h[cyc] = m_amp;
      dc_h[cyc]  = m_dc;
      e_valid = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e_sample = scale(int'($signed(mem[q[0].addr])), amp_h[cyc-1], dc_h[cyc]);
        e_valid  = 1;
        void'(q.pop_front());
      end
      if (phase_reset) begin
        e_addr = int'(m_poff / 64'd4194304);
        if (enable) q.push_back('{due: cyc + LAT, addr: e_addr});
        m_acc  = 0;
        e_wrap = 0;
      end else if (enable) begin
        e_addr = int'(((m_acc + m_poff) % TWO32) / 64'd4194304);
        q.push_back('{due: cyc + LAT, addr: e_addr});
        s_acc  = m_acc + m_ftw;
        e_wrap = (s_acc >= TWO32);
        m_acc  = s_acc % TWO32;
      end else begin
        e_wrap = 0;
      end
      if (load) begin
        m_ftw  = longint'(ftw_in);
        m_poff = longint'(poff_in);
        m_amp  = int'(amp_in);
        m_dc   = int'($signed(dc_in));
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("addr",   ram_address,          e_addr);
      chk("sample", $signed(sample_out),  e_sample);
      chk("valid",  sample_valid,         e_valid);
      chk("wrap",   wrap_pulse,           e_wrap);
      chk("sync",   sync_out,             longint'(m_acc / 64'h8000_0000));
    end
  end

  int  first_valid = -1;
  bit  wcnt_en = 0;
  int  wcnt = 0;
  always @(negedge clk) begin
    if (sample_valid && first_valid < 0) first_valid = cyc;
    if (wcnt_en && wrap_pulse) wcnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] f, input logic [31:0] p,
                         input logic [15:0] a, input logic [15:0] d);
    ftw_in = f; poff_in = p; amp_in = a; dc_in = d; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  typedef struct { logic [15:0] v; logic [15:0] a; logic [15:0] d; int x; string tag; } sc_t;
  sc_t sc [6];

  int first_en;

  initial begin
    reset_n = 1'b0; enable = 1'b0; phase_reset = 1'b0; load = 1'b0;
    ftw_in = '0; poff_in = '0; amp_in = '0; dc_in = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 16);
    tick(3);
    chk("cs", ram_chipselect, 1);
    chk("we", ram_write, 0);
    chk("be", ram_byteenable, 3);
    reset_n = 1'b1;
    tick(2);

    // Ramp across a full table with wrap, then atomic load with half-cycle phase offset
    do_load(32'h0040_0000, 32'h0, 16'h8000, 16'h0);
    tick(2);
    first_valid = -1;
    wcnt = 0; wcnt_en = 1;
    first_en = cyc + 1;
    enable = 1'b1;
    tick(1030);
    do_load(32'h0040_0000, 32'h8000_0000, 16'h4000, 16'd100);
    tick(10);
    wcnt_en = 0;
    chk("latency", first_valid - first_en, LAT);
    chk("ramp_wraps", wcnt, 1);

    // Reset with samples in flight
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    enable = 1'b0;
    tick(6);
    chk("rst_valid", sample_valid, 0);
    chk("rst_sample", $signed(sample_out), 0);

    // Scaling, rounding and saturation corner cases at a fixed address
    sc[0] = '{16'hFFFD, 16'h4000, 16'h0000,     -2, "round_neg"};
    sc[1] = '{16'h0003, 16'h4000, 16'h0000,      1, "round_pos"};
    sc[2] = '{16'h04D2, 16'h0000, 16'h0037,     55, "amp_zero"};
    sc[3] = '{16'h7FFF, 16'hFFFF, 16'h0000,  32767, "sat_pos"};
    sc[4] = '{16'h8000, 16'hFFFF, 16'h0000, -32768, "sat_neg"};
    sc[5] = '{16'h7000, 16'h8000, 16'h2000,  32767, "sat_dc"};
    foreach (sc[k]) begin
      mem[0] = sc[k].v;
      do_load(32'h0, 32'h0, sc[k].a, sc[k].d);
      phase_reset = 1'b1;
      tick(1);
      phase_reset = 1'b0;
      enable = 1'b1;
      tick(8);
      chk(sc[k].tag, $signed(sample_out), sc[k].x);
      enable = 1'b0;
      tick(6);
    end

    // Half-rate wrap/sync, then phase_reset together with enable
    do_load(32'h8000_0000, 32'h0, 16'h8000, 16'h0);
    phase_reset = 1'b1;
    tick(1);
    phase_reset = 1'b0;
    wcnt = 0; wcnt_en = 1;
    enable = 1'b1;
    tick(8);
    phase_reset = 1'b1;
    tick(1);
    chk("pr_wrap", wrap_pulse, 0);
    phase_reset = 1'b0;
    enable = 1'b0;
    tick(3);
    wcnt_en = 0;
    chk("half_wraps", wcnt, 4);
    tick(4);

    // Randomized operation over random waveform content
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom());
    for (int n = 0; n < 3000; n++) begin
      enable      = ($urandom_range(0, 9) < 7);
      phase_reset = ($urandom_range(0, 29) == 0);
      reset_n     = ($urandom_range(0, 399) != 0);
      load        = ($urandom_range(0, 19) == 0);
      ftw_in      = $urandom_range(0, 1) ? $urandom() : ($urandom() >> 12);
      poff_in     = $urandom();
      amp_in      = 16'($urandom());
      dc_in       = 16'($urandom());
      tick(1);
    end
    reset_n = 1'b1; enable = 1'b0; phase_reset = 1'b0; load = 1'b0;
    tick(8);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
